// File: rtl/adc_limit_monitor_if.sv
// Event stream from adc_limit_monitor to the control FSM: one-deep valid/ready channel.
// The master drives valid/ch/type and the slave returns ready.
interface adc_limit_monitor_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_ch;
    logic [1:0] evt_type;

    modport master (
        output evt_valid,
        output evt_ch,
        output evt_type,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        input  evt_type,
        output evt_ready
    );
endinterface

// File: rtl/adc_limit_monitor.sv
// Round-robin hi/lo limit monitor with debounce, hysteresis and a one-deep event port.
// Optional feature: define ALARM_LATCH_EN for sticky alarms cleared through alarm_clr.
module adc_limit_monitor #(
    parameter int unsigned NCH      = 7,
    parameter int unsigned DW       = 12,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned HYST     = 16
) (
    input  logic                   c1m,
    input  logic                   rst_n,
    input  logic [NCH-1:0][DW-1:0] adc_data,
    input  logic [DW-1:0]          hi_th,
    input  logic [DW-1:0]          lo_th,
    input  logic [NCH-1:0]         alarm_clr,
    output logic [NCH-1:0]         alarm_hi,
    output logic [NCH-1:0]         alarm_lo,
    output logic                   any_alarm,
    output logic                   evt_ovf,
    adc_limit_monitor_if.master    evt
);

    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] LastCh = CW'(NCH - 1);
    localparam logic [3:0]    DebCnt = 4'(DEBOUNCE);
    localparam logic [DW-1:0] HystW  = DW'(HYST);

    typedef enum logic [2:0] {StIdle, StHiPend, StHi, StLoPend, StLo} st_e;
    typedef enum logic [1:0] {EvtHiSet = 2'd0, EvtLoSet = 2'd1, EvtClear = 2'd2} evt_e;

    logic [CW-1:0] scan_ch;
    logic          s1_vld;
    logic [DW-1:0] s1_v;
    logic [CW-1:0] s1_ch;

    st_e        st_q  [NCH];
    logic [3:0] cnt_q [NCH];

    st_e        cur_st, nxt_st;
    logic [3:0] cur_cnt, nxt_cnt, cnt_inc;
    logic       over_hi, under_lo;
    logic       new_evt;
    evt_e       new_type;
    logic [DW-1:0] hi_exit, lo_exit;
    logic [DW:0]   lo_sum;
    logic [NCH-1:0] in_hi, in_lo, alarm_hi_d, alarm_lo_d;
    logic           handshake;

    // Exit thresholds saturate so a limit near either rail still has a reachable exit.
    always_comb begin
        hi_exit = (hi_th >= HystW) ? (hi_th - HystW) : '0;
        lo_sum  = {1'b0, lo_th} + {1'b0, HystW};
        lo_exit = lo_sum[DW] ? '1 : lo_sum[DW-1:0];
    end

    always_comb begin
        cur_st   = st_q[s1_ch];
        cur_cnt  = cnt_q[s1_ch];
        cnt_inc  = cur_cnt + 4'd1;
        nxt_st   = cur_st;
        nxt_cnt  = cur_cnt;
        new_evt  = 1'b0;
        new_type = EvtHiSet;
        over_hi  = (s1_v > hi_th);
        under_lo = (s1_v < lo_th);
        unique case (cur_st)
            StIdle: begin
                if (over_hi) begin
                    if (DEBOUNCE <= 1) begin
                        nxt_st   = StHi;
                        nxt_cnt  = '0;
                        new_evt  = 1'b1;
                        new_type = EvtHiSet;
                    end else begin
                        nxt_st  = StHiPend;
                        nxt_cnt = 4'd1;
                    end
                end else if (under_lo) begin
                    if (DEBOUNCE <= 1) begin
                        nxt_st   = StLo;
                        nxt_cnt  = '0;
                        new_evt  = 1'b1;
                        new_type = EvtLoSet;
                    end else begin
                        nxt_st  = StLoPend;
                        nxt_cnt = 4'd1;
                    end
                end
            end
            StHiPend: begin
                if (!over_hi) begin
                    nxt_st  = StIdle;
                    nxt_cnt = '0;
                end else if (cnt_inc >= DebCnt) begin
                    nxt_st   = StHi;
                    nxt_cnt  = '0;
                    new_evt  = 1'b1;
                    new_type = EvtHiSet;
                end else begin
                    nxt_cnt = cnt_inc;
                end
            end
            StLoPend: begin
                if (!under_lo) begin
                    nxt_st  = StIdle;
                    nxt_cnt = '0;
                end else if (cnt_inc >= DebCnt) begin
                    nxt_st   = StLo;
                    nxt_cnt  = '0;
                    new_evt  = 1'b1;
                    new_type = EvtLoSet;
                end else begin
                    nxt_cnt = cnt_inc;
                end
            end
            StHi: begin
                if (s1_v <= hi_exit) begin
                    nxt_st   = StIdle;
                    new_evt  = 1'b1;
                    new_type = EvtClear;
                end
            end
            StLo: begin
                if (s1_v >= lo_exit) begin
                    nxt_st   = StIdle;
                    new_evt  = 1'b1;
                    new_type = EvtClear;
                end
            end
            default: begin
                nxt_st  = StIdle;
                nxt_cnt = '0;
            end
        endcase
        if (!s1_vld) begin
            new_evt = 1'b0;
        end
    end

    always_comb begin
        in_hi = '0;
        in_lo = '0;
        for (int i = 0; i < NCH; i++) begin
            in_hi[i] = (st_q[i] == StHi);
            in_lo[i] = (st_q[i] == StLo);
        end
    end

`ifdef ALARM_LATCH_EN
    // Being in HI/LO keeps the flag set, so a clear is ignored and loses to a set.
    assign alarm_hi_d = in_hi | (alarm_hi & ~alarm_clr);
    assign alarm_lo_d = in_lo | (alarm_lo & ~alarm_clr);
`else
    logic unused_alarm_clr;
    assign unused_alarm_clr = ^alarm_clr;
    assign alarm_hi_d = in_hi;
    assign alarm_lo_d = in_lo;
`endif

    assign handshake = evt.evt_valid & evt.evt_ready;

    always_ff @(posedge c1m) begin
        if (!rst_n) begin
            scan_ch       <= '0;
            s1_vld        <= 1'b0;
            s1_v          <= '0;
            s1_ch         <= '0;
            for (int i = 0; i < NCH; i++) begin
                st_q[i]  <= StIdle;
                cnt_q[i] <= '0;
            end
            alarm_hi      <= '0;
            alarm_lo      <= '0;
            any_alarm     <= 1'b0;
            evt.evt_valid <= 1'b0;
            evt.evt_ch    <= '0;
            evt.evt_type  <= '0;
            evt_ovf       <= 1'b0;
        end else begin
            scan_ch <= (scan_ch == LastCh) ? '0 : scan_ch + 1'b1;
            s1_vld  <= 1'b1;
            s1_v    <= adc_data[scan_ch];
            s1_ch   <= scan_ch;
            if (s1_vld) begin
                st_q[s1_ch]  <= nxt_st;
                cnt_q[s1_ch] <= nxt_cnt;
            end
            alarm_hi  <= alarm_hi_d;
            alarm_lo  <= alarm_lo_d;
            any_alarm <= (|alarm_hi) | (|alarm_lo);
            // A slot freed by this cycle's handshake can take a new event at once.
            if (new_evt) begin
                if (!evt.evt_valid || handshake) begin
                    evt.evt_valid <= 1'b1;
                    evt.evt_ch    <= s1_ch;
                    evt.evt_type  <= new_type;
                end else begin
                    evt_ovf <= 1'b1;
                end
            end else if (handshake) begin
                evt.evt_valid <= 1'b0;
            end
        end
    end

endmodule
